mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be WORD_SIZE, 16, data/address width.
REQ-002 Parameters SHALL include TIMEOUT_CYCLES, 255, maximum wait cycles for a memory response.
REQ-003 There SHALL be one clock; reset is asynchronous and active-low (ports clk, reset_n).
REQ-004 Ports SHALL be the following, one per line:
- clk  in  1  clock, rising edge.
- reset_n  in  1  async active-low reset.
- if_req  in  1  fetch read request, held until if_done.
- if_addr  in  WORD_SIZE  fetch address.
- if_rdata  out  WORD_SIZE  fetched word.
- if_done  out  1  one-cycle completion pulse, fetch.
- d_req  in  1  data request, held until d_done.
- d_we  in  1  1=write, 0=read.
- d_addr  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  store data.
- d_rdata  out  WORD_SIZE  loaded word.
- d_done  out  1  one-cycle completion pulse, data.
- readM  out  1  memory read strobe.
- writeM  out  1  memory write strobe.
- address  out  WORD_SIZE  memory address.
- data  inout  WORD_SIZE  memory data bus.
- inputReady  in  1  memory read data valid.
- ackOutput  in  1  memory write accepted.
- busy  out  1  transaction in progress.
- err  out  1  one-cycle timeout pulse.

Function
REQ-005 FSM states SHALL be IDLE, RD, RD_REL, WR, WR_REL.
REQ-006 In IDLE, arbitration SHALL be sampled each cycle: d_req beats if_req; d_req with d_we=1 goes to WR, otherwise RD.
REQ-007 On grant, address, grant owner and (for writes) d_wdata SHALL be registered; later requester input changes SHALL be ignored until return to IDLE.
REQ-008 readM SHALL be 1 exactly in RD; writeM SHALL be 1 exactly in WR; both SHALL never be 1 together.
REQ-009 data SHALL be driven with the registered write word only in WR and WR_REL; otherwise it SHALL be high-Z.
REQ-010 In RD, on the first cycle with inputReady=1, data SHALL be latched into the owner's rdata register, the owner's done SHALL pulse, and the FSM SHALL go to RD_REL.
REQ-011 In WR, on the first cycle with ackOutput=1, the owner's done SHALL pulse and the FSM SHALL go to WR_REL.
REQ-012 RD_REL and WR_REL SHALL hold until inputReady or ackOutput, respectively, is 0, then go to IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-013 Minimum latency SHALL be: grant cycle, then strobe for 1 or more cycles, then done in the response cycle.
REQ-014 Deasserting a request mid-transaction SHALL NOT abort the transaction; done SHALL still pulse.
REQ-015 After a data grant, if if_req is pending, fetch SHALL win the next arbitration (one-shot fetch anti-starvation).
REQ-016 busy SHALL be 1 in every state other than IDLE.
REQ-017 if_rdata and d_rdata SHALL hold their values until the next read completes for the same owner.

Reset
REQ-018 Asserting reset_n=0 at any time SHALL immediately force IDLE, readM=writeM=0, data high-Z, done/err/busy=0, rdata=0, counter=0.
REQ-019 An in-flight transaction SHALL be discarded on reset, with no done pulse.

Configuration
REQ-020 With MEM_TIMEOUT_EN defined, a counter SHALL run in RD/WR; at TIMEOUT_CYCLES without response the strobe SHALL drop, err and the owner's done SHALL pulse, rdata SHALL be unchanged, and the FSM SHALL go to IDLE.
REQ-021 Without MEM_TIMEOUT_EN, RD/WR SHALL wait indefinitely and err SHALL be tied 0.

Structure
REQ-022 Package mem_arb_pkg SHALL hold WORD_SIZE, the FSM state encoding and owner codes (OWN_IF, OWN_D).
REQ-023 Sub-module mem_arb_timer (load/enable/expire counter) SHALL be instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-024 if_req=1, if_addr=16'h0004, inputReady high 2 cycles after readM -> address=16'h0004, if_rdata=memory word, one if_done pulse.
REQ-025 d_req=1, d_we=1, d_addr=16'h0010, d_wdata=16'hBEEF, together with if_req -> write first, data=16'hBEEF while writeM, then fetch granted.
REQ-026 d_req read at 16'h0020 while inputReady held high 3 cycles -> single d_done, FSM waits in RD_REL until inputReady=0.
REQ-027 reset_n=0 pulse during RD -> readM=0 asynchronously, no done, next request served normally.
REQ-028 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no inputReady -> readM drops after 4 cycles, err and if_done pulse together.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: word width, FSM state
// encoding and grant-owner codes.
package mem_arb_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_REL = 3'd2,
    WR     = 3'd3,
    WR_REL = 3'd4
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Response-timeout counter: cleared while load_i is high, counts while en_i is
// high, and flags expire_o during the LIMIT-th enabled cycle.
module mem_arb_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  assign expire_o = en_i && (count_q == CW'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i && !expire_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one handshaked memory bus.
// Completion pulses are registered, so if_done/d_done arrive together with the
// updated rdata. Define MEM_TIMEOUT_EN to enable the response timeout.
module mem_port_arbiter #(
  parameter int WORD_SIZE      = mem_arb_pkg::WORD_SIZE,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic                 busy,
  output logic                 err
);

  import mem_arb_pkg::*;

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 if_done_q, if_done_d;
  logic                 d_done_q, d_done_d;
  logic                 fetch_prio_q, fetch_prio_d;
  logic                 done_now;
  logic                 expire;

`ifdef MEM_TIMEOUT_EN
  logic err_q;
  logic timed_out;

  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (state_q == IDLE),
    .en_i     ((state_q == RD) || (state_q == WR)),
    .expire_o (expire)
  );

  // A response arriving in the expiry cycle still wins over the timeout.
  assign timed_out = expire && (((state_q == RD) && !inputReady) ||
                                ((state_q == WR) && !ackOutput));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timed_out;
    end
  end

  assign err = err_q;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    fetch_prio_d = fetch_prio_q;
    done_now     = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins unless the previous grant went to data and fetch is waiting.
        if (if_req && (fetch_prio_q || !d_req)) begin
          owner_d      = OWN_IF;
          addr_d       = if_addr;
          fetch_prio_d = 1'b0;
          state_d      = RD;
        end else if (d_req) begin
          owner_d      = OWN_D;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          fetch_prio_d = 1'b1;
          state_d      = d_we ? WR : RD;
        end
      end
      RD: begin
        if (inputReady) begin
          if (owner_q == OWN_IF) if_rdata_d = data;
          else                   d_rdata_d  = data;
          done_now = 1'b1;
          state_d  = RD_REL;
        end else if (expire) begin
          done_now = 1'b1;
          state_d  = IDLE;
        end
      end
      RD_REL: begin
        if (!inputReady) state_d = IDLE;
      end
      WR: begin
        if (ackOutput) begin
          done_now = 1'b1;
          state_d  = WR_REL;
        end else if (expire) begin
          done_now = 1'b1;
          state_d  = IDLE;
        end
      end
      WR_REL: begin
        if (!ackOutput) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if_done_d = done_now && (owner_q == OWN_IF);
    d_done_d  = done_now && (owner_q == OWN_D);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      fetch_prio_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      fetch_prio_q <= fetch_prio_d;
    end
  end

  assign readM    = (state_q == RD);
  assign writeM   = (state_q == WR);
  assign busy     = (state_q != IDLE);
  assign address  = addr_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_done  = if_done_q;
  assign d_done   = d_done_q;
  assign data     = ((state_q == WR) || (state_q == WR_REL)) ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle vectors plus
// hand-written reset-during-read and (with MEM_TIMEOUT_EN) timeout sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we, inputReady, ackOutput;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic [15:0] if_rdata, d_rdata, address;
  logic        if_done, d_done, readM, writeM, busy, err;
  logic        mem_oe;
  logic [15:0] mem_drv;
  wire  [15:0] data;

  int n_total = 0;
  int n_pass  = 0;

  assign data = mem_oe ? mem_drv : 16'hzzzz;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_SIZE      (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_done     (d_done),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady),
    .ackOutput  (ackOutput),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        ir;
    logic        ack;
    logic [15:0] mem_rd;
    logic        readm;
    logic        writem;
    logic [15:0] addr;
    logic        busy;
    logic        if_done;
    logic        d_done;
    logic [15:0] if_rdata;
    logic [15:0] d_rdata;
    logic        chk_data;
    logic [15:0] bus;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic ir_i, input logic [15:0] mem_rd_i);
    inputReady = ir_i;
    mem_oe     = ir_i;
    mem_drv    = mem_rd_i;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         if  if_addr  d  we d_addr   d_wdata  ir ack mem_rd  | rM wM addr     bsy ifd dd if_rdata d_rdata  chk bus
    vecs[0]  = '{1, 16'h0004, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0, 1, 16'h0010, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF};
    vecs[1]  = '{1, 16'h0004, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0, 1, 16'h0010, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF};
    vecs[2]  = '{1, 16'h0004, 1, 1, 16'h0010, 16'hBEEF, 0, 1, 16'h0000, 0, 0, 16'h0010, 1, 0, 1, 16'h0000, 16'h0000, 1, 16'hBEEF};
    vecs[3]  = '{1, 16'h0004, 0, 1, 16'h0010, 16'hBEEF, 0, 1, 16'h0000, 0, 0, 16'h0010, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF};
    vecs[4]  = '{1, 16'h0004, 0, 0, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    vecs[5]  = '{1, 16'h0004, 1, 1, 16'h0030, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'h0004, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    vecs[6]  = '{1, 16'h0004, 1, 1, 16'h0030, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'h0004, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    vecs[7]  = '{1, 16'h0004, 1, 1, 16'h0030, 16'h1234, 1, 0, 16'hA5C7, 0, 0, 16'h0004, 1, 1, 0, 16'hA5C7, 16'h0000, 0, 16'h0000};
    vecs[8]  = '{0, 16'h0004, 1, 1, 16'h0030, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0004, 0, 0, 0, 16'hA5C7, 16'h0000, 0, 16'h0000};
    vecs[9]  = '{0, 16'h0004, 1, 1, 16'h0030, 16'h1234, 0, 0, 16'h0000, 0, 1, 16'h0030, 1, 0, 0, 16'hA5C7, 16'h0000, 1, 16'h1234};
    vecs[10] = '{0, 16'h0004, 1, 1, 16'h0030, 16'h1234, 0, 1, 16'h0000, 0, 0, 16'h0030, 1, 0, 1, 16'hA5C7, 16'h0000, 1, 16'h1234};
    vecs[11] = '{0, 16'h0004, 0, 0, 16'h0030, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0030, 0, 0, 0, 16'hA5C7, 16'h0000, 0, 16'h0000};
    vecs[12] = '{0, 16'h0004, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0020, 1, 0, 0, 16'hA5C7, 16'h0000, 0, 16'h0000};
    vecs[13] = '{0, 16'h0004, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'hA5E3, 0, 0, 16'h0020, 1, 0, 1, 16'hA5C7, 16'hA5E3, 0, 16'h0000};
    vecs[14] = '{0, 16'h0004, 0, 0, 16'h0020, 16'h0000, 1, 0, 16'hA5E3, 0, 0, 16'h0020, 1, 0, 0, 16'hA5C7, 16'hA5E3, 0, 16'h0000};
    vecs[15] = '{0, 16'h0004, 0, 0, 16'h0020, 16'h0000, 1, 0, 16'hA5E3, 0, 0, 16'h0020, 1, 0, 0, 16'hA5C7, 16'hA5E3, 0, 16'h0000};
    vecs[16] = '{0, 16'h0004, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0020, 0, 0, 0, 16'hA5C7, 16'hA5E3, 0, 16'h0000};
    vecs[17] = '{1, 16'h0040, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0040, 1, 0, 0, 16'hA5C7, 16'hA5E3, 0, 16'h0000};
    vecs[18] = '{0, 16'h0099, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0040, 1, 0, 0, 16'hA5C7, 16'hA5E3, 0, 16'h0000};
    vecs[19] = '{0, 16'h0099, 0, 0, 16'h0020, 16'h0000, 1, 0, 16'hA583, 0, 0, 16'h0040, 1, 1, 0, 16'hA583, 16'hA5E3, 0, 16'h0000};
    vecs[20] = '{0, 16'h0099, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0040, 0, 0, 0, 16'hA583, 16'hA5E3, 0, 16'h0000};
    vecs[21] = '{1, 16'h0060, 1, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0070, 1, 0, 0, 16'hA583, 16'hA5E3, 0, 16'h0000};
    vecs[22] = '{1, 16'h0060, 1, 0, 16'h0070, 16'h0000, 1, 0, 16'h1111, 0, 0, 16'h0070, 1, 0, 1, 16'hA583, 16'h1111, 0, 16'h0000};
    vecs[23] = '{1, 16'h0060, 0, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0070, 0, 0, 0, 16'hA583, 16'h1111, 0, 16'h0000};
    vecs[24] = '{1, 16'h0060, 0, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0060, 1, 0, 0, 16'hA583, 16'h1111, 0, 16'h0000};
    vecs[25] = '{1, 16'h0060, 0, 0, 16'h0070, 16'h0000, 1, 0, 16'h2222, 0, 0, 16'h0060, 1, 1, 0, 16'h2222, 16'h1111, 0, 16'h0000};
    vecs[26] = '{0, 16'h0060, 0, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0060, 0, 0, 0, 16'h2222, 16'h1111, 0, 16'h0000};

    reset_n = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    ackOutput = 0;
    drive(1'b0, 16'h0000);

    #12;
    check("reset readM",    readM,    0);
    check("reset writeM",   writeM,   0);
    check("reset busy",     busy,     0);
    check("reset if_done",  if_done,  0);
    check("reset d_done",   d_done,   0);
    check("reset err",      err,      0);
    check("reset if_rdata", if_rdata, 16'h0000);
    check("reset d_rdata",  d_rdata,  16'h0000);
    #10 reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if_req    = vecs[i].if_req;
      if_addr   = vecs[i].if_addr;
      d_req     = vecs[i].d_req;
      d_we      = vecs[i].d_we;
      d_addr    = vecs[i].d_addr;
      d_wdata   = vecs[i].d_wdata;
      ackOutput = vecs[i].ack;
      drive(vecs[i].ir, vecs[i].mem_rd);
      step();
      check($sformatf("v%0d readM", i),    readM,    vecs[i].readm);
      check($sformatf("v%0d writeM", i),   writeM,   vecs[i].writem);
      check($sformatf("v%0d address", i),  address,  vecs[i].addr);
      check($sformatf("v%0d busy", i),     busy,     vecs[i].busy);
      check($sformatf("v%0d if_done", i),  if_done,  vecs[i].if_done);
      check($sformatf("v%0d d_done", i),   d_done,   vecs[i].d_done);
      check($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].if_rdata);
      check($sformatf("v%0d d_rdata", i),  d_rdata,  vecs[i].d_rdata);
      check($sformatf("v%0d err", i),      err,      0);
      if (vecs[i].chk_data) check($sformatf("v%0d data", i), data, vecs[i].bus);
    end

    // Reset pulse in the middle of a read: strobe drops at once, no done.
    if_req = 1; if_addr = 16'h0080;
    drive(1'b0, 16'h0000);
    step();
    check("rst-rd readM before", readM, 1);
    #3 reset_n = 1'b0;
    if_req = 0;
    drive(1'b1, 16'h7777);
    #1;
    check("rst-rd readM async",  readM,    0);
    check("rst-rd busy async",   busy,     0);
    check("rst-rd address",      address,  16'h0000);
    check("rst-rd if_rdata",     if_rdata, 16'h0000);
    check("rst-rd d_rdata",      d_rdata,  16'h0000);
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("rst-rd if_done c%0d", k), if_done, 0);
      check($sformatf("rst-rd readM c%0d", k),   readM,   0);
    end
    drive(1'b0, 16'h0000);
    #2 reset_n = 1'b1;
    check("post-rst if_done", if_done, 0);
    if_req = 1; if_addr = 16'h0090;
    step();
    check("post-rst readM",   readM,   1);
    check("post-rst address", address, 16'h0090);
    drive(1'b1, 16'h3333);
    step();
    check("post-rst if_done",  if_done,  1);
    check("post-rst if_rdata", if_rdata, 16'h3333);
    if_req = 0;
    drive(1'b0, 16'h0000);
    step();
    check("post-rst busy", busy, 0);

`ifdef MEM_TIMEOUT_EN
    // No response: strobe for 4 cycles, then err and if_done together.
    if_req = 1; if_addr = 16'h0050;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("tmo readM c%0d", c), readM, 1);
      check($sformatf("tmo err c%0d", c),   err,   0);
    end
    step();
    check("tmo readM drop", readM,    0);
    check("tmo err pulse",  err,      1);
    check("tmo if_done",    if_done,  1);
    check("tmo if_rdata",   if_rdata, 16'h3333);
    check("tmo busy",       busy,     0);
    if_req = 0;
    step();
    check("tmo err clear",  err,     0);
    check("tmo done clear", if_done, 0);
    check("tmo idle",       busy,    0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
